// File: rtl/dct_product_accumulator_if.sv
// rtl/dct_product_accumulator_if.sv - product stream in, rounded coefficient stream out
// master drives products and out_ready; slave is the accumulator.
interface dct_product_accumulator_if #(
  parameter int PW    = 16,
  parameter int ACC_W = 20,
  parameter int SHIFT = 3,
  parameter int N_OUT = 8
);
  localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int OUT_W = ACC_W - SHIFT;

  logic [PW-1:0]           prod_in;
  logic                    prod_neg;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [K_W-1:0]          out_k;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output prod_in, prod_neg, in_valid, out_ready,
    input  in_ready, out_data, out_k, out_valid
  );

  modport slave (
    input  prod_in, prod_neg, in_valid, out_ready,
    output in_ready, out_data, out_k, out_valid
  );
endinterface

// File: rtl/dct_product_accumulator.sv
// rtl/dct_product_accumulator.sv - sums N_TERMS signed products into one rounded DCT coefficient
// Tracks the output index k and holds each result until the consumer takes it.
module dct_product_accumulator #(
  parameter int PW      = 16,
  parameter int N_TERMS = 8,
  parameter int N_OUT   = 8,
  parameter int ACC_W   = 20,
  parameter int SHIFT   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  dct_product_accumulator_if.slave bus
);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int OUT_W = ACC_W - SHIFT;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic [K_W-1:0]          K_LAST   = K_W'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'((2 ** SHIFT) / 2);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [K_W-1:0]          out_k_q, out_k_d;
  logic                    out_valid_q, out_valid_d;

  logic                    last;
  logic                    in_ready;
  logic                    accept;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    last     = (cnt_q == CNT_LAST);
    // Only the closing term has to wait for the output register to free up.
    in_ready = !clr && !(last && out_valid_q && !bus.out_ready);
    accept   = bus.in_valid && in_ready;

    term = $signed({{(ACC_W-PW){1'b0}}, bus.prod_in});
    if (bus.prod_neg) term = -term;
    sum     = ((cnt_q == '0) ? '0 : acc_q) + term;
    rounded = sum + RND;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      k_d   = '0;
    end else if (accept) begin
      if (last) begin
        out_data_d  = OUT_W'(rounded >>> SHIFT);
        out_k_d     = k_q;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        k_d         = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_k     = out_k_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_dct_product_accumulator.sv
// tb/tb_dct_product_accumulator.sv - directed-vector bench for dct_product_accumulator
module tb_dct_product_accumulator;
  localparam int PW = 16, N_TERMS = 8, N_OUT = 8, ACC_W = 20, SHIFT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;
  int   passed = 0;
  int   total  = 0;

  dct_product_accumulator_if #(.PW(PW), .ACC_W(ACC_W), .SHIFT(SHIFT), .N_OUT(N_OUT)) bus ();

  dct_product_accumulator #(
    .PW(PW), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input int data, input int k);
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_data"}, int'($signed(bus.out_data)), data);
    check({tag, "_k"}, int'(bus.out_k), k);
  endtask

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic send(input int p, input bit neg);
    int t;
    bus.prod_in  = PW'(p);
    bus.prod_neg = neg;
    bus.in_valid = 1'b1;
    #1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t == 20) check("send_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input int p, input bit neg);
    for (int i = 0; i < N_TERMS; i++) send(p, neg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.prod_in   = '0;
    bus.prod_neg  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'($signed(bus.out_data)), 0);
    check("rst_k", int'(bus.out_k), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    bus.out_ready = 1'b1;
    send_vec(100, 1'b0);
    check_out("pos100", 100, 0);
    @(negedge clk);
    check("drain_valid", int'(bus.out_valid), 0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N_TERMS; i++) send(1000, i[0]);
      check_out("alt", 0, (1 + v) % 8);
    end

    send_vec(65025, 1'b0);
    check_out("max_pos", 65025, 1);
    send_vec(65025, 1'b1);
    check_out("max_neg", -65025, 2);

    bus.out_ready = 1'b0;
    for (int i = 0; i < N_TERMS - 1; i++) send(200, 1'b0);
    bus.prod_in  = 16'd200;
    bus.prod_neg = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    #1;
    check("bp_in_ready_hold", int'(bus.in_ready), 0);
    check_out("bp_hold", -65025, 2);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("bp_new", 200, 3);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(50, 1'b0);
    clr          = 1'b1;
    bus.prod_in  = 16'd999;
    bus.in_valid = 1'b1;
    #1;
    check("clr_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check_out("clr_keep", 200, 3);
    bus.out_ready = 1'b1;
    send_vec(8, 1'b0);
    check_out("clr", 8, 0);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_data", int'($signed(bus.out_data)), 0);
    check("arst_k", int'(bus.out_k), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_vec(16, 1'b0);
    check_out("post_rst", 16, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
